imem_fetch_ctrl: RTL and testbench

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

---
 rtl/imem_fetch_ctrl.sv | 135 +++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: drives a combinational instruction memory,
// registers one instruction per advance, and arbitrates memory ownership with a program loader.
module imem_fetch_ctrl #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter logic [63:0] RESET_PC  = 64'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        halt,
    input  logic        load_req,
    input  logic        load_done,
    output logic        load_gnt,
    output logic [63:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        br_taken,
    input  logic [63:0] br_target,
    input  logic        if_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc,
    output logic        fault
);

    typedef enum logic [1:0] {
        ST_HALT,
        ST_FETCH,
        ST_LOAD,
        ST_FAULT
    } state_t;

    state_t      state_reg;
    logic [63:0] pc_reg;
    logic        if_valid_reg;
    logic [31:0] if_instr_reg;
    logic [63:0] if_pc_reg;
    logic        load_gnt_reg;
    logic        fault_reg;

    logic        advance;
    logic        pc_bad;
    logic        target_bad;

    // Widened by one bit so addresses near 2^64 cannot wrap below MEM_BYTES.
    function automatic logic addr_bad(input logic [63:0] addr);
        logic [64:0] last_byte;
        last_byte = {1'b0, addr} + 65'd3;
        return (addr[1:0] != 2'b00) || (last_byte >= 65'(MEM_BYTES));
    endfunction

    assign advance    = !if_valid_reg || if_ready;
    assign pc_bad     = addr_bad(pc_reg);
    assign target_bad = addr_bad(br_target);

    assign mem_addr = pc_reg;
    assign if_valid = if_valid_reg;
    assign if_instr = if_instr_reg;
    assign if_pc    = if_pc_reg;
    assign load_gnt = load_gnt_reg;
    assign fault    = fault_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_HALT;
            pc_reg       <= RESET_PC;
            if_valid_reg <= 1'b0;
            if_instr_reg <= 32'd0;
            if_pc_reg    <= 64'd0;
            load_gnt_reg <= 1'b0;
            fault_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_HALT: begin
                    if_valid_reg <= 1'b0;
                    if (load_req) begin
                        state_reg    <= ST_LOAD;
                        load_gnt_reg <= 1'b1;
                    end else if (start) begin
                        state_reg <= ST_FETCH;
                    end
                end

                ST_LOAD: begin
                    if_valid_reg <= 1'b0;
                    if (load_done) begin
                        state_reg    <= ST_HALT;
                        load_gnt_reg <= 1'b0;
                        pc_reg       <= RESET_PC;
                        fault_reg    <= 1'b0;
                    end
                end

                ST_FETCH: begin
                    // A redirect squashes even a stalled instruction and outranks halt.
                    if (br_taken) begin
                        if_valid_reg <= 1'b0;
                        if (target_bad) begin
                            state_reg <= ST_FAULT;
                            fault_reg <= 1'b1;
                        end else begin
                            pc_reg <= br_target;
                            if (halt) begin
                                state_reg <= ST_HALT;
                            end
                        end
                    end else if (halt) begin
                        state_reg    <= ST_HALT;
                        if_valid_reg <= 1'b0;
                    end else if (advance) begin
                        if (pc_bad) begin
                            state_reg    <= ST_FAULT;
                            fault_reg    <= 1'b1;
                            if_valid_reg <= 1'b0;
                        end else begin
                            if_instr_reg <= mem_rdata;
                            if_pc_reg    <= pc_reg;
                            if_valid_reg <= 1'b1;
                            pc_reg       <= pc_reg + 64'd4;
                        end
                    end
                end

                ST_FAULT: begin
                    fault_reg    <= 1'b1;
                    if_valid_reg <= 1'b0;
                end

                default: begin
                    state_reg <= ST_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed and randomized check of imem_fetch_ctrl against a cycle-level behavioural model.
module tb_imem_fetch_ctrl;

    localparam int unsigned MB     = 1024;
    localparam logic [63:0] RPC    = 64'd0;
    localparam int          NWORDS = MB / 4;
    localparam int          AW     = $clog2(MB);

    localparam int MODE_IDLE    = 0;
    localparam int MODE_RUN     = 1;
    localparam int MODE_LOADING = 2;
    localparam int MODE_DEAD    = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, halt, load_req, load_done, load_gnt;
    logic [63:0] mem_addr, br_target, if_pc;
    logic [31:0] mem_rdata, if_instr;
    logic        br_taken, if_ready, if_valid, fault;

    logic [31:0] mem_arr [NWORDS];

    int n_checks = 0;
    int n_fail   = 0;

    int          m_mode;
    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_instr;
    bit          m_valid, m_fault;

    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr < 64'(MB)) ? mem_arr[mem_addr[AW-1:2]] : 32'hDEAD_BEEF;

    imem_fetch_ctrl #(.MEM_BYTES(MB), .RESET_PC(RPC)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .halt(halt),
        .load_req(load_req), .load_done(load_done), .load_gnt(load_gnt),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .br_taken(br_taken), .br_target(br_target), .if_ready(if_ready),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .fault(fault)
    );

    function automatic bit illegal(input logic [63:0] a);
        return (a % 64'd4 != 64'd0) || (a > 64'(MB) - 64'd4);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = MODE_IDLE; m_pc = RPC; m_valid = 0; m_instr = '0; m_ipc = '0; m_fault = 0;
    endtask

    // Next-cycle behaviour from the current inputs, stated as the prose rules.
    task automatic model_step();
        if (m_mode == MODE_IDLE) begin
            if (load_req) m_mode = MODE_LOADING;
            else if (start) m_mode = MODE_RUN;
        end else if (m_mode == MODE_LOADING) begin
            if (load_done) begin m_mode = MODE_IDLE; m_pc = RPC; m_fault = 0; end
        end else if (m_mode == MODE_RUN) begin
            if (br_taken) begin
                m_valid = 0;
                if (illegal(br_target)) begin m_mode = MODE_DEAD; m_fault = 1; end
                else begin m_pc = br_target; if (halt) m_mode = MODE_IDLE; end
            end else if (halt) begin
                m_mode = MODE_IDLE; m_valid = 0;
            end else if (!m_valid || if_ready) begin
                if (illegal(m_pc)) begin m_mode = MODE_DEAD; m_fault = 1; m_valid = 0; end
                else begin
                    m_instr = mem_arr[m_pc[AW-1:2]]; m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 64'd4;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("if_valid", if_valid, m_valid);
        check("fault", fault, m_fault);
        check("load_gnt", load_gnt, m_mode == MODE_LOADING);
        if (m_valid) begin
            check("if_instr", if_instr, m_instr);
            check("if_pc", if_pc, m_ipc);
        end
        if (m_mode == MODE_RUN) check("mem_addr", mem_addr, m_pc);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        start = 0; halt = 0; load_req = 0; load_done = 0; br_taken = 0; br_target = '0; if_ready = 1;
    endtask

    // Reset takes effect immediately, checked before any clock edge.
    task automatic do_reset();
        reset_n = 0;
        #1;
        model_reset();
        check("rst_valid", if_valid, 1'b0);
        check("rst_gnt", load_gnt, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_instr", if_instr, 64'd0);
        check("rst_pc", if_pc, 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1;
        clear_inputs();
    endtask

    initial begin
        reset_n = 0;
        clear_inputs();
        for (int i = 0; i < NWORDS; i++) mem_arr[i] = $urandom;
        mem_arr[0] = 32'hAAAA_0001;
        do_reset();

        // Basic fetch stream.
        start = 1; tick(); start = 0;
        check("start_novalid", if_valid, 1'b0);
        tick();
        check("first_valid", if_valid, 1'b1);
        check("first_instr", if_instr, 64'hAAAA_0001);
        check("first_pc", if_pc, 64'h0);
        tick(); check("seq_pc4", if_pc, 64'h4);
        tick(); check("seq_pc8", if_pc, 64'h8);

        // Stall for three cycles.
        if_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", if_pc, 64'h8);
            check("stall_instr", if_instr, mem_arr[2]);
        end
        if_ready = 1; tick();
        check("resume_pc", if_pc, 64'hC);
        check("resume_instr", if_instr, mem_arr[3]);

        // Redirect while stalled.
        if_ready = 0; br_taken = 1; br_target = 64'h40; tick(); br_taken = 0;
        check("squash_valid", if_valid, 1'b0);
        if_ready = 1; tick();
        check("branch_pc", if_pc, 64'h40);
        check("branch_instr", if_instr, mem_arr[16]);

        // Halt, then loader handshake.
        halt = 1; tick(); halt = 0;
        check("halt_valid", if_valid, 1'b0);
        load_req = 1; tick(); load_req = 0;
        check("gnt_on", load_gnt, 1'b1);
        tick(); tick();
        load_done = 1; tick(); load_done = 0;
        check("gnt_off", load_gnt, 1'b0);
        start = 1; tick(); start = 0; tick();
        check("after_load_pc", if_pc, RPC);

        // Halt then resume at the retained pc.
        halt = 1; tick(); halt = 0;
        start = 1; tick(); start = 0; tick();
        check("resume_retained_pc", if_pc, 64'h4);

        // Reset in the middle of a load.
        halt = 1; tick(); halt = 0;
        load_req = 1; tick(); load_req = 0; tick();
        check("mid_load_gnt", load_gnt, 1'b1);
        do_reset();

        // Misaligned redirect target.
        start = 1; tick(); start = 0; tick();
        br_taken = 1; br_target = 64'h42; tick(); br_taken = 0;
        check("misalign_fault", fault, 1'b1);
        check("misalign_valid", if_valid, 1'b0);
        load_req = 1; tick(); load_req = 0;
        check("fault_ignores_load", load_gnt, 1'b0);
        start = 1; tick(); start = 0; tick();
        check("fault_sticky", fault, 1'b1);
        do_reset();

        // Out-of-range redirect target.
        start = 1; tick(); start = 0;
        br_taken = 1; br_target = 64'h400; tick(); br_taken = 0;
        check("oob_fault", fault, 1'b1);
        do_reset();

        // Sequential run off the end of memory.
        start = 1; tick(); start = 0;
        br_taken = 1; br_target = 64'h3F8; tick(); br_taken = 0;
        tick(); check("end_pc0", if_pc, 64'h3F8);
        tick(); check("end_pc1", if_pc, 64'h3FC);
        tick();
        check("wrap_fault", fault, 1'b1);
        check("wrap_valid", if_valid, 1'b0);

        // Randomized traffic.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int c = 0; c < 400; c++) begin
                start     = ($urandom_range(0, 9) == 0);
                halt      = ($urandom_range(0, 29) == 0);
                load_req  = ($urandom_range(0, 39) == 0);
                load_done = ($urandom_range(0, 4) == 0);
                if_ready  = ($urandom_range(0, 9) < 7);
                br_taken  = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 29) == 0) br_target = 64'($urandom_range(0, 2047));
                else br_target = {54'd0, 8'($urandom_range(0, 255)), 2'b00};
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
